// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: operand forwarding, 32-bit ALU, iterative mul/div with HI/LO, EX/MEM register.
// Optional feature macro: EX_OVERFLOW_TRAP_EN adds o_ovf and suppresses regWrite on signed ADD/SUB overflow.
module execute_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int MD_CYC  = 32
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_halt,
  input  logic               i_flush,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [4:0]         i_shamt,
  input  logic [3:0]         i_alu_op,
  input  logic               i_alu_src,
  input  logic [1:0]         i_hilo_sel,
  input  logic [1:0]         i_fwd_a,
  input  logic [1:0]         i_fwd_b,
  input  logic [NB_DATA-1:0] i_mem_fwd,
  input  logic [NB_DATA-1:0] i_wb_fwd,
  input  logic [NB_REG-1:0]  i_reg2write,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic               i_mem2reg,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  output logic [NB_DATA-1:0] o_result,
  output logic [NB_DATA-1:0] o_data4Mem,
  output logic [NB_REG-1:0]  o_reg2write,
  output logic [1:0]         o_width,
  output logic               o_sign_flag,
  output logic               o_mem2reg,
  output logic               o_memRead,
  output logic               o_memWrite,
  output logic               o_regWrite,
`ifdef EX_OVERFLOW_TRAP_EN
  output logic               o_ovf,
`endif
  output logic               o_busy
);

  localparam int NB_CNT = (MD_CYC > 1) ? $clog2(MD_CYC) : 1;
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(MD_CYC - 1);

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} mdState_t;

  mdState_t                 r_state, w_nextState;
  logic [2*NB_DATA-1:0]     r_acc, w_step, w_prod;
  logic [NB_DATA-1:0]       r_opARaw, r_opBMag, r_hi, r_lo;
  logic [NB_CNT-1:0]        r_cnt;
  logic                     r_negA, r_negB, r_isDiv;

  logic [NB_DATA-1:0]       w_a, w_rtFwd, w_b, w_sum, w_diff, w_aluRes, w_exResult;
  logic [NB_DATA-1:0]       w_aMag, w_bMag, w_remSub, w_mdHi, w_mdLo;
  logic [NB_DATA:0]         w_mulSum, w_remSh;
  logic                     w_isMd, w_readsHiLo, w_start, w_negA, w_negB, w_regWriteEn;

  always_comb begin
    case (i_fwd_a)
      2'b01:   w_a = i_mem_fwd;
      2'b10:   w_a = i_wb_fwd;
      default: w_a = i_rs_data;
    endcase
    case (i_fwd_b)
      2'b01:   w_rtFwd = i_mem_fwd;
      2'b10:   w_rtFwd = i_wb_fwd;
      default: w_rtFwd = i_rt_data;
    endcase
  end

  assign w_b         = i_alu_src ? i_imm : w_rtFwd;
  assign w_sum       = w_a + w_b;
  assign w_diff      = w_a - w_b;
  assign w_isMd      = (i_alu_op[3:2] == 2'b11);
  assign w_readsHiLo = (i_hilo_sel == 2'b01) || (i_hilo_sel == 2'b10);
  assign o_busy      = (r_state != MD_IDLE) && (w_readsHiLo || w_isMd);
  assign w_start     = (r_state == MD_IDLE) && w_isMd && !i_flush;

  always_comb begin
    w_aluRes = '0;
    case (i_alu_op)
      4'h0: w_aluRes = w_sum;
      4'h1: w_aluRes = w_diff;
      4'h2: w_aluRes = w_a & w_b;
      4'h3: w_aluRes = w_a | w_b;
      4'h4: w_aluRes = w_a ^ w_b;
      4'h5: w_aluRes = ~(w_a | w_b);
      4'h6: w_aluRes = {{(NB_DATA-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      4'h7: w_aluRes = {{(NB_DATA-1){1'b0}}, (w_a < w_b)};
      4'h8: w_aluRes = w_b << i_shamt;
      4'h9: w_aluRes = w_b >> i_shamt;
      4'hA: w_aluRes = $signed(w_b) >>> i_shamt;
      4'hB: w_aluRes = {i_imm[NB_DATA/2-1:0], {(NB_DATA/2){1'b0}}};
      default: w_aluRes = '0;
    endcase
  end

  assign w_exResult = (i_hilo_sel == 2'b01) ? r_hi :
                      (i_hilo_sel == 2'b10) ? r_lo : w_aluRes;

`ifdef EX_OVERFLOW_TRAP_EN
  logic w_ovf;
  assign w_ovf = !w_readsHiLo &&
                 (((i_alu_op == 4'h0) && (w_a[NB_DATA-1] == w_b[NB_DATA-1]) &&
                   (w_sum[NB_DATA-1] != w_a[NB_DATA-1])) ||
                  ((i_alu_op == 4'h1) && (w_a[NB_DATA-1] != w_b[NB_DATA-1]) &&
                   (w_diff[NB_DATA-1] != w_a[NB_DATA-1])));
  assign w_regWriteEn = i_regWrite && !w_isMd && !w_ovf;
`else
  assign w_regWriteEn = i_regWrite && !w_isMd;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_result    <= '0;
      o_data4Mem  <= '0;
      o_reg2write <= '0;
      o_width     <= '0;
      o_sign_flag <= 1'b0;
      o_mem2reg   <= 1'b0;
      o_memRead   <= 1'b0;
      o_memWrite  <= 1'b0;
      o_regWrite  <= 1'b0;
`ifdef EX_OVERFLOW_TRAP_EN
      o_ovf       <= 1'b0;
`endif
    end else if (!i_halt) begin
      o_result    <= w_exResult;
      o_data4Mem  <= w_rtFwd;
      o_reg2write <= i_reg2write;
      o_width     <= i_width;
      o_sign_flag <= i_sign_flag;
      o_mem2reg   <= i_mem2reg;
      if (i_flush || o_busy) begin
        o_memRead  <= 1'b0;
        o_memWrite <= 1'b0;
        o_regWrite <= 1'b0;
`ifdef EX_OVERFLOW_TRAP_EN
        o_ovf      <= 1'b0;
`endif
      end else begin
        o_memRead  <= i_memRead && !w_isMd;
        o_memWrite <= i_memWrite && !w_isMd;
        o_regWrite <= w_regWriteEn;
`ifdef EX_OVERFLOW_TRAP_EN
        o_ovf      <= w_ovf;
`endif
      end
    end
  end

  // Signed ops iterate on magnitudes; the sign is restored in DONE.
  assign w_negA = !i_alu_op[0] && w_a[NB_DATA-1];
  assign w_negB = !i_alu_op[0] && w_rtFwd[NB_DATA-1];
  assign w_aMag = w_negA ? -w_a : w_a;
  assign w_bMag = w_negB ? -w_rtFwd : w_rtFwd;

  assign w_mulSum = {1'b0, r_acc[2*NB_DATA-1:NB_DATA]} + (r_acc[0] ? {1'b0, r_opBMag} : '0);
  assign w_remSh  = r_acc[2*NB_DATA-1:NB_DATA-1];
  assign w_remSub = w_remSh[NB_DATA-1:0] - r_opBMag;

  always_comb begin
    w_step = r_acc;
    if (!r_isDiv)
      w_step = {w_mulSum, r_acc[NB_DATA-1:1]};
    else if (w_remSh >= {1'b0, r_opBMag})
      w_step = {w_remSub, r_acc[NB_DATA-2:0], 1'b1};
    else
      w_step = {w_remSh[NB_DATA-1:0], r_acc[NB_DATA-2:0], 1'b0};
  end

  always_comb begin
    w_prod = (r_negA ^ r_negB) ? -r_acc : r_acc;
    w_mdHi = w_prod[2*NB_DATA-1:NB_DATA];
    w_mdLo = w_prod[NB_DATA-1:0];
    if (r_isDiv) begin
      if (r_opBMag == '0) begin
        w_mdLo = '1;
        w_mdHi = r_opARaw;
      end else begin
        w_mdLo = (r_negA ^ r_negB) ? -r_acc[NB_DATA-1:0] : r_acc[NB_DATA-1:0];
        w_mdHi = r_negA ? -r_acc[2*NB_DATA-1:NB_DATA] : r_acc[2*NB_DATA-1:NB_DATA];
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      MD_IDLE: if (w_start) w_nextState = MD_RUN;
      MD_RUN:  if (r_cnt == LAST_CNT) w_nextState = MD_DONE;
      MD_DONE: w_nextState = MD_IDLE;
      default: w_nextState = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_state <= MD_IDLE;
    else if (!i_halt) r_state <= w_nextState;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opARaw <= '0;
      r_opBMag <= '0;
      r_negA   <= 1'b0;
      r_negB   <= 1'b0;
      r_isDiv  <= 1'b0;
    end else if (!i_halt) begin
      case (r_state)
        MD_IDLE: if (w_start) begin
          r_acc    <= {{NB_DATA{1'b0}}, w_aMag};
          r_opBMag <= w_bMag;
          r_opARaw <= w_a;
          r_negA   <= w_negA;
          r_negB   <= w_negB;
          r_isDiv  <= i_alu_op[1];
          r_cnt    <= '0;
        end
        MD_RUN: begin
          r_acc <= w_step;
          r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + NB_CNT'(1);
        end
        MD_DONE: begin
          r_hi <= w_mdHi;
          r_lo <= w_mdLo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed spec vectors plus randomized ALU and mul/div traffic
// checked against a plain-arithmetic reference model of the EX stage and HI/LO.
module tb_execute_stage;
  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int MD_CYC  = 32;

  typedef struct {
    logic [31:0] rs, rt, imm, memFwd, wbFwd;
    logic [4:0]  shamt, rd;
    logic [3:0]  op;
    logic        aluSrc, signFlag, mem2reg, memRead, memWrite, regWrite, flush, halt;
    logic [1:0]  hilo, fwdA, fwdB, width;
  } stim_t;

  logic clk = 1'b0;
  logic i_rst_n, i_halt, i_flush, i_alu_src, i_sign_flag, i_mem2reg, i_memRead, i_memWrite, i_regWrite;
  logic [31:0] i_rs_data, i_rt_data, i_imm, i_mem_fwd, i_wb_fwd;
  logic [4:0]  i_shamt, i_reg2write;
  logic [3:0]  i_alu_op;
  logic [1:0]  i_hilo_sel, i_fwd_a, i_fwd_b, i_width;
  logic [31:0] o_result, o_data4Mem;
  logic [4:0]  o_reg2write;
  logic [1:0]  o_width;
  logic        o_sign_flag, o_mem2reg, o_memRead, o_memWrite, o_regWrite, o_busy;
`ifdef EX_OVERFLOW_TRAP_EN
  logic        o_ovf;
`endif

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  always #5 clk = ~clk;

  execute_stage #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .MD_CYC(MD_CYC)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_halt(i_halt), .i_flush(i_flush),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm), .i_shamt(i_shamt),
    .i_alu_op(i_alu_op), .i_alu_src(i_alu_src), .i_hilo_sel(i_hilo_sel),
    .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b), .i_mem_fwd(i_mem_fwd), .i_wb_fwd(i_wb_fwd),
    .i_reg2write(i_reg2write), .i_width(i_width), .i_sign_flag(i_sign_flag),
    .i_mem2reg(i_mem2reg), .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_regWrite(i_regWrite),
    .o_result(o_result), .o_data4Mem(o_data4Mem), .o_reg2write(o_reg2write), .o_width(o_width),
    .o_sign_flag(o_sign_flag), .o_mem2reg(o_mem2reg), .o_memRead(o_memRead),
    .o_memWrite(o_memWrite), .o_regWrite(o_regWrite),
`ifdef EX_OVERFLOW_TRAP_EN
    .o_ovf(o_ovf),
`endif
    .o_busy(o_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic stim_t zeroStim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic [31:0] randWord();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t genAlu();
    stim_t s;
    s = zeroStim();
    s.op       = 4'($urandom_range(0, 11));
    s.rs       = randWord();
    s.rt       = randWord();
    s.imm      = randWord();
    s.memFwd   = randWord();
    s.wbFwd    = randWord();
    s.shamt    = 5'($urandom_range(0, 31));
    s.rd       = 5'($urandom_range(0, 31));
    s.aluSrc   = 1'($urandom_range(0, 1));
    s.hilo     = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    s.fwdA     = 2'($urandom_range(0, 3));
    s.fwdB     = 2'($urandom_range(0, 3));
    s.width    = 2'($urandom_range(0, 3));
    s.signFlag = 1'($urandom_range(0, 1));
    s.mem2reg  = 1'($urandom_range(0, 1));
    s.memRead  = 1'($urandom_range(0, 1));
    s.memWrite = 1'($urandom_range(0, 1));
    s.regWrite = 1'($urandom_range(0, 1));
    s.flush    = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  function automatic logic [31:0] fwdVal(input logic [1:0] sel, input logic [31:0] id, input logic [31:0] mem,
                                         input logic [31:0] wb);
    if (sel == 2'd1) return mem;
    if (sel == 2'd2) return wb;
    return id;
  endfunction

  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sh, input logic [31:0] imm);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~(a | b);
      4'h6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h7: return (a < b) ? 32'd1 : 32'd0;
      4'h8: return b << sh;
      4'h9: return b >> sh;
      4'hA: return (b >> sh) | (b[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
      4'hB: return imm << 16;
      default: return 32'h0;
    endcase
  endfunction

  task automatic refMd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint q, r;
    case (op)
      4'hC: begin p = longint'($signed(a)) * longint'($signed(b)); {mHi, mLo} = p; end
      4'hD: begin p = {32'h0, a} * {32'h0, b}; {mHi, mLo} = p; end
      default: begin
        if (b == 32'h0) begin
          mLo = 32'hFFFFFFFF;
          mHi = a;
        end else if (op == 4'hE) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          mLo = q[31:0];
          mHi = r[31:0];
        end else begin
          mLo = a / b;
          mHi = a % b;
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input stim_t s);
    i_rs_data = s.rs;   i_rt_data = s.rt;   i_imm = s.imm;   i_shamt = s.shamt;
    i_alu_op = s.op;    i_alu_src = s.aluSrc; i_hilo_sel = s.hilo;
    i_fwd_a = s.fwdA;   i_fwd_b = s.fwdB;   i_mem_fwd = s.memFwd; i_wb_fwd = s.wbFwd;
    i_reg2write = s.rd; i_width = s.width;  i_sign_flag = s.signFlag; i_mem2reg = s.mem2reg;
    i_memRead = s.memRead; i_memWrite = s.memWrite; i_regWrite = s.regWrite;
    i_flush = s.flush;  i_halt = s.halt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Registered outputs expected one edge after s was presented, with the unit not busy.
  task automatic checkEx(input stim_t s, input string tag);
    logic [31:0] a, rt, b, expRes;
    logic isMd, ovf;
`ifdef EX_OVERFLOW_TRAP_EN
    longint sa, sb, res;
`endif
    a    = fwdVal(s.fwdA, s.rs, s.memFwd, s.wbFwd);
    rt   = fwdVal(s.fwdB, s.rt, s.memFwd, s.wbFwd);
    b    = s.aluSrc ? s.imm : rt;
    isMd = (s.op >= 4'hC);
    ovf  = 1'b0;
`ifdef EX_OVERFLOW_TRAP_EN
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 0;
    if (s.hilo != 2'd1 && s.hilo != 2'd2) begin
      if (s.op == 4'h0) res = sa + sb;
      if (s.op == 4'h1) res = sa - sb;
    end
    ovf = (res > 64'sd2147483647) || (res < -64'sd2147483648);
`endif
    if (s.hilo == 2'd1)      expRes = mHi;
    else if (s.hilo == 2'd2) expRes = mLo;
    else                     expRes = refAlu(s.op, a, b, s.shamt, s.imm);
    if (s.flush) begin
      checkOutput({tag, "_flushRegWrite"}, 32'(o_regWrite), 32'd0);
      checkOutput({tag, "_flushMemRead"}, 32'(o_memRead), 32'd0);
      checkOutput({tag, "_flushMemWrite"}, 32'(o_memWrite), 32'd0);
    end else begin
      if (!isMd) checkOutput({tag, "_result"}, o_result, expRes);
      checkOutput({tag, "_data4Mem"}, o_data4Mem, rt);
      checkOutput({tag, "_reg2write"}, 32'(o_reg2write), 32'(s.rd));
      checkOutput({tag, "_width"}, 32'(o_width), 32'(s.width));
      checkOutput({tag, "_signFlag"}, 32'(o_sign_flag), 32'(s.signFlag));
      checkOutput({tag, "_mem2reg"}, 32'(o_mem2reg), 32'(s.mem2reg));
      checkOutput({tag, "_memRead"}, 32'(o_memRead), 32'(s.memRead && !isMd));
      checkOutput({tag, "_memWrite"}, 32'(o_memWrite), 32'(s.memWrite && !isMd));
      checkOutput({tag, "_regWrite"}, 32'(o_regWrite), 32'(s.regWrite && !isMd && !ovf));
`ifdef EX_OVERFLOW_TRAP_EN
      checkOutput({tag, "_ovf"}, 32'(o_ovf), 32'(ovf));
`endif
    end
  endtask

  task automatic readHiLo(input logic [1:0] sel, input string tag);
    stim_t m;
    m = zeroStim();
    m.hilo = sel;
    m.regWrite = 1'b1;
    m.rd = 5'd9;
    applyStimulus(m);
    #1;
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    tick();
    checkEx(m, tag);
  endtask

  // Issue a mul/div op, optionally overlap independent ALU ops, then read LO (stalling) and HI.
  task automatic runMd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int extra,
                       input string tag);
    stim_t s, g, m;
    int n;
    s = zeroStim();
    s.op = op; s.rs = a; s.rt = b; s.regWrite = 1'b1; s.memRead = 1'b1; s.memWrite = 1'b1; s.rd = 5'd3;
    applyStimulus(s);
    #1;
    checkOutput({tag, "_issueBusy"}, 32'(o_busy), 32'd0);
    tick();
    checkEx(s, {tag, "_issue"});
    refMd(op, a, b);
    for (int k = 0; k < extra; k++) begin
      g = genAlu();
      g.flush = 1'b0;
      applyStimulus(g);
      #1;
      checkOutput({tag, "_overlapBusy"}, 32'(o_busy), 32'd0);
      tick();
      checkEx(g, {tag, "_overlap"});
    end
    m = zeroStim();
    m.hilo = 2'd2; m.regWrite = 1'b1; m.rd = 5'd8;
    applyStimulus(m);
    #1;
    n = 0;
    while (o_busy && n < 200) begin
      tick();
      n++;
    end
    checkOutput({tag, "_stallCycles"}, 32'(n), 32'(MD_CYC + 1 - extra));
    tick();
    checkEx(m, {tag, "_mflo"});
    readHiLo(2'd1, {tag, "_mfhi"});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s, m;
    int n;
    applyStimulus(zeroStim());
    i_rst_n = 1'b0;
    tick();
    tick();
    checkOutput("reset_result", o_result, 32'h0);
    checkOutput("reset_data4Mem", o_data4Mem, 32'h0);
    checkOutput("reset_regWrite", 32'(o_regWrite), 32'd0);
    checkOutput("reset_memRead", 32'(o_memRead), 32'd0);
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    i_rst_n = 1'b1;
    readHiLo(2'd2, "reset_lo");
    readHiLo(2'd1, "reset_hi");

    s = zeroStim(); s.op = 4'h0; s.rs = 32'h7FFFFFFF; s.rt = 32'h1; s.regWrite = 1'b1; s.rd = 5'd4;
    applyStimulus(s); tick(); checkEx(s, "add_ovf");
    checkOutput("add_ovf_value", o_result, 32'h80000000);

    s = zeroStim(); s.op = 4'h1; s.fwdA = 2'd1; s.memFwd = 32'd5; s.rs = 32'd100; s.rt = 32'd3; s.regWrite = 1'b1;
    applyStimulus(s); tick(); checkEx(s, "sub_fwd");
    checkOutput("sub_fwd_value", o_result, 32'd2);

    s = zeroStim(); s.op = 4'h0; s.aluSrc = 1'b1; s.imm = 32'd16; s.rs = 32'h1000; s.fwdB = 2'd2;
    s.wbFwd = 32'd9; s.rt = 32'd77; s.memWrite = 1'b1;
    applyStimulus(s); tick(); checkEx(s, "sw_fwd");
    checkOutput("sw_fwd_data", o_data4Mem, 32'd9);

    s = zeroStim(); s.op = 4'h0; s.aluSrc = 1'b1; s.imm = 32'd4; s.memRead = 1'b1; s.regWrite = 1'b1;
    s.mem2reg = 1'b1; s.flush = 1'b1;
    applyStimulus(s); tick(); checkEx(s, "lw_flush");

    s = zeroStim(); s.op = 4'hA; s.rt = 32'h80000000; s.shamt = 5'd4; s.regWrite = 1'b1;
    applyStimulus(s); tick(); checkEx(s, "sra");
    checkOutput("sra_value", o_result, 32'hF8000000);

    s = zeroStim(); s.op = 4'h7; s.rs = 32'h1; s.rt = 32'hFFFFFFFF; s.regWrite = 1'b1;
    applyStimulus(s); tick(); checkEx(s, "sltu");
    checkOutput("sltu_value", o_result, 32'd1);

    runMd(4'hC, 32'hFFFFFFFE, 32'd3, 0, "mult_neg");
    checkOutput("mult_neg_lo", mLo, 32'hFFFFFFFA);
    runMd(4'hE, 32'hFFFFFFF9, 32'd2, 0, "div_neg");
    runMd(4'hF, 32'd10, 32'd0, 0, "divu_zero");

    s = zeroStim(); s.op = 4'h0; s.rs = 32'd2; s.rt = 32'd3; s.regWrite = 1'b1;
    applyStimulus(s); tick(); checkEx(s, "halt_pre");
    s.op = 4'h1; s.rs = 32'd10; s.rt = 32'd1; s.halt = 1'b1;
    applyStimulus(s); tick();
    checkOutput("halt_hold_result", o_result, 32'd5);
    s.halt = 1'b0;
    applyStimulus(s); tick(); checkEx(s, "halt_release");

    s = zeroStim(); s.op = 4'hC; s.rs = 32'd5; s.rt = 32'd6;
    applyStimulus(s); tick();
    refMd(4'hC, 32'd5, 32'd6);
    m = zeroStim(); m.hilo = 2'd2; m.regWrite = 1'b1; m.halt = 1'b1;
    applyStimulus(m);
    #1;
    checkOutput("haltRun_busy", 32'(o_busy), 32'd1);
    for (int k = 0; k < 5; k++) tick();
    m.halt = 1'b0;
    applyStimulus(m);
    #1;
    n = 0;
    while (o_busy && n < 200) begin
      tick();
      n++;
    end
    checkOutput("haltRun_stallCycles", 32'(n), 32'(MD_CYC + 1));
    tick();
    checkEx(m, "haltRun_mflo");

    s = zeroStim(); s.op = 4'hD; s.rs = 32'h1234; s.rt = 32'h10;
    applyStimulus(s); tick();
    applyStimulus(zeroStim());
    for (int k = 0; k < 10; k++) tick();
    #2 i_rst_n = 1'b0;
    #2;
    checkOutput("midReset_result", o_result, 32'h0);
    checkOutput("midReset_regWrite", 32'(o_regWrite), 32'd0);
    i_rst_n = 1'b1;
    mHi = 32'h0;
    mLo = 32'h0;
    readHiLo(2'd2, "midReset_lo");
    readHiLo(2'd1, "midReset_hi");

    runMd(4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, "multu_max");
    s = zeroStim(); s.op = 4'hF; s.rs = 32'd100; s.rt = 32'd7; s.flush = 1'b1;
    applyStimulus(s); tick(); checkEx(s, "mdFlush");
    readHiLo(2'd2, "mdFlush_lo");

    for (int k = 0; k < 12; k++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'(12 + $urandom_range(0, 3));
      a  = randWord();
      b  = ($urandom_range(0, 4) == 0) ? 32'h0 : randWord();
      runMd(op, a, b, $urandom_range(0, 3), $sformatf("rmd%0d", k));
    end

    for (int k = 0; k < 200; k++) begin
      s = genAlu();
      applyStimulus(s);
      #1;
      checkOutput("ralu_busy", 32'(o_busy), 32'd0);
      tick();
      checkEx(s, $sformatf("ralu%0d_op%0h", k, s.op));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
